// File: rtl/tmr_vote_monitor.sv
// Registered triple-modular-redundancy voter with per-lane disagreement tracking,
// saturating error counters and sticky consecutive-mismatch fault flags.
module tmr_vote_monitor #(
    parameter int W            = 8,
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    input  logic             CLR_FAULT,
    output logic             O_VALID,
    output logic [W-1:0]     O,
    output logic [2:0]       MISMATCH,
    output logic [CNT_W-1:0] ERR_A,
    output logic [CNT_W-1:0] ERR_B,
    output logic [CNT_W-1:0] ERR_C,
    output logic [2:0]       FAULT,
    output logic             DEGRADED
);

    localparam logic [3:0]       THRESH  = 4'(FAULT_THRESH);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic [2:0][W-1:0] lanes;
    logic [W-1:0]      vote;
    logic [2:0]        mm;

    logic              o_valid_q, o_valid_d;
    logic [W-1:0]      o_q, o_d;
    logic [2:0]        mm_q, mm_d;
    logic [CNT_W-1:0]  err_q [3];
    logic [CNT_W-1:0]  err_d [3];
    logic [3:0]        cons_q [3];
    logic [3:0]        cons_d [3];
    logic [2:0]        fault_q, fault_d;
    logic              degraded_q, degraded_d;

    assign lanes = {C, B, A};
    assign vote  = (A & B) | (A & C) | (B & C);
    assign mm[0] = |(A ^ vote);
    assign mm[1] = |(B ^ vote);
    assign mm[2] = |(C ^ vote);

    always_comb begin
        o_valid_d = IN_VALID;
        o_d       = o_q;
        mm_d      = mm_q;
        fault_d   = fault_q;
        for (int k = 0; k < 3; k++) begin
            err_d[k]  = err_q[k];
            cons_d[k] = cons_q[k];
        end

        if (IN_VALID) begin
            o_d  = vote;
            mm_d = mm;
        end

        for (int k = 0; k < 3; k++) begin
            // A clear wipes history first so a same-cycle sample starts a fresh run.
            if (CLR_FAULT) begin
                cons_d[k]  = '0;
                fault_d[k] = 1'b0;
            end
            if (IN_VALID) begin
                if (mm[k]) begin
                    if (err_q[k] != ERR_MAX) begin
                        err_d[k] = err_q[k] + 1'b1;
                    end
                    if (cons_d[k] != THRESH) begin
                        cons_d[k] = cons_d[k] + 1'b1;
                    end
                    if (cons_d[k] == THRESH) begin
                        fault_d[k] = 1'b1;
                    end
                end else begin
                    cons_d[k] = '0;
                end
            end
        end

        degraded_d = (fault_d[0] & fault_d[1]) | (fault_d[0] & fault_d[2]) |
                     (fault_d[1] & fault_d[2]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            o_valid_q  <= 1'b0;
            o_q        <= '0;
            mm_q       <= '0;
            fault_q    <= '0;
            degraded_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                err_q[k]  <= '0;
                cons_q[k] <= '0;
            end
        end else begin
            o_valid_q  <= o_valid_d;
            o_q        <= o_d;
            mm_q       <= mm_d;
            fault_q    <= fault_d;
            degraded_q <= degraded_d;
            for (int k = 0; k < 3; k++) begin
                err_q[k]  <= err_d[k];
                cons_q[k] <= cons_d[k];
            end
        end
    end

    assign O_VALID  = o_valid_q;
    assign O        = o_q;
    assign MISMATCH = mm_q;
    assign ERR_A    = err_q[0];
    assign ERR_B    = err_q[1];
    assign ERR_C    = err_q[2];
    assign FAULT    = fault_q;
    assign DEGRADED = degraded_q;

endmodule
